// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   sweep_state_t          - sequencer states
//   popcount()             - set-bit count used for the mismatch counter
//   N_IN_DEFAULT,
//   SETTLE_CYCLES_DEFAULT  - default build parameters
package sweep_pkg;

    localparam int N_IN_DEFAULT          = 3;
    localparam int SETTLE_CYCLES_DEFAULT = 1;

    // popcount works on a fixed-width operand; callers zero-extend into it.
    // 256 bits covers tables up to N_IN = 8.
    localparam int POP_MAX = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that measures the settle window of each vector.
// Latency: zero flag reflects the registered count (1 cycle after load).
// Backpressure: none; load has priority over decrement, which stops at zero.
//
// Ports:
//   clk, reset     - clock, async active-high reset (count -> 0)
//   load, load_val - reload the count
//   en             - decrement while non-zero
//   zero           - count == 0
module sweep_settle_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a combinational datapath through every input vector, captures y, and compares with a golden table.
// Latency: N_VEC*(SETTLE_CYCLES+1) cycles in DRIVE plus 1 cycle in DONE; pass/mismatch_cnt valid with done.
// Backpressure: none; start is ignored while busy, abort cancels a sweep on the next edge.
//
// Ports:
//   clk, reset       - clock, async active-high reset
//   start, abort     - begin sweep (IDLE only) / cancel sweep (abort wins)
//   exp_table        - golden table, latched on accepted start
//   y                - datapath output under test
//   vec              - datapath input vector (MSB = first input)
//   busy, done       - sweep in progress / one-cycle completion pulse
//   table_out        - captured table, bit i = y for vector i
//   pass, mismatch_cnt - comparison result, valid from done until next start
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter  int N_IN          = N_IN_DEFAULT,
    parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    localparam int N_VEC         = 2 ** N_IN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [N_VEC-1:0] exp_table,
    input  logic             y,
    output logic [N_IN-1:0]  vec,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_out,
    output logic             pass,
    output logic [N_IN:0]    mismatch_cnt
);

    localparam int              CNT_W       = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int              MM_W        = N_IN + 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0]  IDX_LAST    = '1;

    sweep_state_t       state;
    sweep_state_t       state_nxt;
    logic [N_IN-1:0]    idx;
    logic [N_VEC-1:0]   exp_q;

    logic               start_ok;
    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;
    logic               sample_now;

    // Table with the bit currently being sampled merged in. The final
    // comparison is taken from this so pass/mismatch_cnt can be registered
    // on the same edge that captures the last vector.
    logic [N_VEC-1:0]   table_nxt;
    logic [N_VEC-1:0]   diff;
    logic [POP_MAX-1:0] pop_in;
    logic               pass_nxt;
    logic [MM_W-1:0]    mm_nxt;

    sweep_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    assign start_ok = (state == IDLE) && start && !abort;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state / control ----------------
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt  = DRIVE;
                    timer_load = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer_zero) begin
                    sample_now = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- result look-ahead ----------------
    always_comb begin
        table_nxt      = table_out;
        table_nxt[idx] = y;
        diff           = table_nxt ^ exp_q;
        pop_in         = '0;
        pop_in[N_VEC-1:0] = diff;
        pass_nxt       = (diff == '0);
        mm_nxt         = MM_W'(popcount(pop_in));
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            vec          <= '0;
            exp_q        <= '0;
            table_out    <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        exp_q        <= exp_table;
                        idx          <= '0;
                        vec          <= '0;
                        table_out    <= '0;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        // Partial table is kept for inspection.
                        vec          <= '0;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                    end else if (sample_now) begin
                        table_out <= table_nxt;
                        if (idx == IDX_LAST) begin
                            pass         <= pass_nxt;
                            mismatch_cnt <= mm_nxt;
                            done         <= 1'b1;
                        end else begin
                            idx <= idx + N_IN'(1);
                            vec <= idx + N_IN'(1);
                        end
                    end
                end
                DONE: begin
                    vec <= '0;
                    if (abort) begin
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                    end
                end
                default: begin
                    vec <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: two sweeper builds (SETTLE_CYCLES = 1 and 0) swept in parallel over
// a datapath whose truth table is a bench variable, checked cycle by cycle
// against expectations derived from the sweep timing rules.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] exp_table;
    logic [7:0] dp_tbl;

    logic       y1, y0;
    logic [2:0] vec1, vec0;
    logic       busy1, busy0, done1, done0, pass1, pass0;
    logic [7:0] tbl1, tbl0;
    logic [3:0] mm1, mm0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Datapath under test: y is the dp_tbl entry for the presented vector.
    assign y1 = dp_tbl[vec1];
    assign y0 = dp_tbl[vec0];

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .exp_table(exp_table), .y(y1), .vec(vec1), .busy(busy1),
        .done(done1), .table_out(tbl1), .pass(pass1), .mismatch_cnt(mm1)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut_s0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .exp_table(exp_table), .y(y0), .vec(vec0), .busy(busy0),
        .done(done0), .table_out(tbl0), .pass(pass0), .mismatch_cnt(mm0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected outputs of one instance k cycles after its start was accepted.
    task automatic check_inst(input int s, input int k, input int abort_k,
                              input logic [7:0] dp, input logic [7:0] ex,
                              input logic o_busy, input logic o_done,
                              input logic [2:0] o_vec, input logic [7:0] o_tbl,
                              input logic o_pass, input logic [3:0] o_mm);
        int  len;
        bit  ab;
        int  e_busy, e_done, e_vec, e_pass, e_mm;
        bit  chk_tbl;
        len     = 8 * (s + 1);
        ab      = (abort_k >= 0) && (abort_k <= len) && (k > abort_k);
        chk_tbl = 1'b0;
        if (ab) begin
            e_busy = 0; e_done = 0; e_vec = 0; e_pass = 0; e_mm = 0;
        end else if (k < len) begin
            e_busy = 1; e_done = 0; e_vec = k / (s + 1); e_pass = 0; e_mm = 0;
        end else begin
            e_busy  = (k == len) ? 1 : 0;
            e_done  = (k == len) ? 1 : 0;
            e_vec   = (k == len) ? 7 : 0;
            e_pass  = (dp == ex) ? 1 : 0;
            e_mm    = $countones(dp ^ ex);
            chk_tbl = 1'b1;
        end
        chk($sformatf("s%0d.k%0d.busy", s, k), 32'(o_busy), e_busy);
        chk($sformatf("s%0d.k%0d.done", s, k), 32'(o_done), e_done);
        chk($sformatf("s%0d.k%0d.vec",  s, k), 32'(o_vec),  e_vec);
        chk($sformatf("s%0d.k%0d.pass", s, k), 32'(o_pass), e_pass);
        chk($sformatf("s%0d.k%0d.mm",   s, k), 32'(o_mm),   e_mm);
        if (chk_tbl) begin
            chk($sformatf("s%0d.k%0d.table", s, k), 32'(o_tbl), 32'(dp));
        end
    endtask

    // One sweep on both builds. restart_k: cycle to re-pulse start and swap
    // exp_table to ex2 (-1 = none). abort_k: cycle to pulse abort (-1 = none).
    task automatic run_sweep(input logic [7:0] dp, input logic [7:0] ex,
                             input int restart_k, input logic [7:0] ex2,
                             input int abort_k);
        dp_tbl    = dp;
        exp_table = ex;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check_inst(1, k, abort_k, dp, ex, busy1, done1, vec1, tbl1, pass1, mm1);
            check_inst(0, k, abort_k, dp, ex, busy0, done0, vec0, tbl0, pass0, mm0);
            start = (k == restart_k);
            abort = (k == abort_k);
            if (k == restart_k) exp_table = ex2;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".vec1"},  32'(vec1),  0);
        chk({tag, ".busy1"}, 32'(busy1), 0);
        chk({tag, ".done1"}, 32'(done1), 0);
        chk({tag, ".tbl1"},  32'(tbl1),  0);
        chk({tag, ".pass1"}, 32'(pass1), 0);
        chk({tag, ".mm1"},   32'(mm1),   0);
        chk({tag, ".vec0"},  32'(vec0),  0);
        chk({tag, ".busy0"}, 32'(busy0), 0);
        chk({tag, ".tbl0"},  32'(tbl0),  0);
        chk({tag, ".pass0"}, 32'(pass0), 0);
        chk({tag, ".mm0"},   32'(mm0),   0);
    endtask

    initial begin
        int mode, rk, ak;
        logic [7:0] dp, ex, ex2;

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        exp_table = 8'h00;
        dp_tbl    = 8'h00;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // (a&b)|c datapath, matching / one-off / fully inverted golden tables.
        run_sweep(8'hEA, 8'hEA, -1, 8'h00, -1);
        run_sweep(8'hEA, 8'hE8, -1, 8'h00, -1);
        run_sweep(8'hEA, 8'h15, -1, 8'h00, -1);
        // start re-pulsed at vector 3 with a different golden table: ignored.
        run_sweep(8'hEA, 8'hEA, 6, 8'h00, -1);
        // abort while the slow build presents vector 5.
        run_sweep(8'hEA, 8'hEA, -1, 8'h00, 10);

        // abort and start together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start.busy1", 32'(busy1), 0);
        chk("abort_start.busy0", 32'(busy0), 0);
        run_sweep(8'hEA, 8'hEA, -1, 8'h00, -1);

        // Asynchronous reset mid-DRIVE, observed before the next clock edge.
        dp_tbl    = 8'h5A;
        exp_table = 8'h5A;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        run_sweep(8'hEA, 8'hE8, -1, 8'h00, -1);

        // Randomized sweeps.
        for (int it = 0; it < 20; it++) begin
            dp   = 8'($urandom);
            ex   = ($urandom_range(0, 1) == 1) ? dp : 8'($urandom);
            ex2  = 8'($urandom);
            mode = $urandom_range(0, 2);
            rk   = (mode == 1) ? $urandom_range(0, 8)  : -1;
            ak   = (mode == 2) ? $urandom_range(0, 17) : -1;
            run_sweep(dp, ex, rk, ex2, ak);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that drives a small combinational datapath (N_IN single-bit inputs, one output y) through every input combination in ascending binary order. It holds each vector for a programmable settle time, samples y, and builds the full truth table. It then compares the table against a golden table latched at start, reporting pass/fail and the mismatch count. It sits in the lab self-check harness in place of a hand-written per-vector display sequence.

Parameters:
N_IN, 3, number of datapath inputs; N_VEC = 2**N_IN vectors.
SETTLE_CYCLES, 1, extra cycles each vector is held before y is sampled (0 allowed).

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  begin sweep; honoured only in IDLE.
abort  input  1  synchronous cancel of a running sweep.
exp_table  input  N_VEC  golden truth table, bit i = expected y for vector i; latched on accepted start.
y  input  1  datapath output under test.
vec  output  N_IN  drives datapath inputs; MSB = first input (a), LSB = last (c).
busy  output  1  high from the cycle after start is accepted until DONE is exited.
done  output  1  one-cycle pulse when a sweep completes (not on abort).
table_out  output  N_VEC  captured truth table, bit i = sampled y for vector i.
pass  output  1  table_out == latched exp_table; valid from the done pulse, held until the next start.
mismatch_cnt  output  N_IN+1  popcount(table_out ^ exp_table); same validity as pass.

Behaviour:
- Reset (async, any state): state=IDLE; vec=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, idx=0, cnt=0, exp latch=0.
- States: IDLE, DRIVE, DONE.
- IDLE with start=1: exp latch<=exp_table; idx<=0; vec<=0; cnt<=SETTLE_CYCLES; table_out<=0; pass<=0; mismatch_cnt<=0; goto DRIVE.
- DRIVE, cnt!=0: cnt<=cnt-1; vec is held.
- DRIVE, cnt==0: table_out[idx]<=y.
  - If idx==N_VEC-1: goto DONE.
  - Else: idx<=idx+1; vec<=idx+1; cnt<=SETTLE_CYCLES.
- Timing: each vector is presented for exactly SETTLE_CYCLES+1 cycles and sampled on the last edge. Sweep length is N_VEC*(SETTLE_CYCLES+1) cycles in DRIVE, plus 1 cycle in DONE.
- DONE: pass and mismatch_cnt are registered from the final table (including the bit sampled on entry). They must be visible in the same cycle that done=1. done=1 for exactly this one cycle; then goto IDLE.
- Pipelining requirement: compute pass/mismatch_cnt combinationally from table_out-with-last-bit and register them on the DRIVE->DONE edge, so they are already valid during DONE.
- busy=1 in DRIVE and DONE, 0 in IDLE.
- start while busy: ignored, with no effect on idx, cnt or exp latch.
- abort in DRIVE or DONE: goto IDLE next edge; done is not pulsed; pass=0, mismatch_cnt=0; table_out keeps its partial contents; vec<=0.
- abort and start together in IDLE: abort wins and start is ignored.
- vec returns to 0 on entering IDLE. idx wraps are impossible because the last index terminates the sweep.
- The y input is sampled directly and is assumed stable within the settle window. No synchronizer is used (same clock domain).

Decomposition:
- Package sweep_pkg holds:
  - typedef enum logic [1:0] {IDLE, DRIVE, DONE} sweep_state_t;
  - function popcount used for mismatch_cnt;
  - default constants for N_IN and SETTLE_CYCLES.
- One sub-module, sweep_settle_timer: a loadable down-counter (load, load_val, zero flag) sized $clog2(SETTLE_CYCLES+1), minimum 1 bit.
- FSM, index and table live in the top module.

Test Plan:
- Datapath y=(a&b)|c, SETTLE_CYCLES=1, exp_table=8'hEA, start pulse -> vec steps 0..7, each held 2 cycles; done after 17 cycles in busy; table_out=8'hEA, pass=1, mismatch_cnt=0.
- Same datapath, exp_table=8'hE8 -> table_out=8'hEA, pass=0, mismatch_cnt=1. Then exp_table=8'h15 -> mismatch_cnt=8.
- SETTLE_CYCLES=0 build -> one vector per cycle; done asserted 9 cycles after start is accepted; table_out correct.
- Start re-pulsed at vector 3 mid-sweep, and exp_table changed mid-sweep -> no restart; result uses the exp_table latched at the original start.
- Abort asserted while vec=5 -> IDLE next cycle; busy=0, vec=0, no done pulse, pass=0; a following start runs a full clean sweep.
- Reset asserted asynchronously mid-DRIVE (between edges) -> all outputs 0 immediately, without waiting for a clock edge; after reset is released, start produces a normal sweep.
